// File: rtl/os_pkg.sv
// Shared definitions for the output-stationary psum drain controller:
// tile instruction encodings and FSM state codes.
package os_pkg;

    // Tile instruction bus encodings
    localparam logic [1:0] INST_HOLD  = 2'b00;
    localparam logic [1:0] INST_CLEAR = 2'b01;
    localparam logic [1:0] INST_EXEC  = 2'b10;

    // Controller state encoding
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_EXEC    = 3'd1;
    localparam state_t ST_SETTLE  = 3'd2;
    localparam state_t ST_CAPTURE = 3'd3;
    localparam state_t ST_CLEAR   = 3'd4;
    localparam state_t ST_DRAIN   = 3'd5;

endpackage

// File: rtl/os_drain_buf.sv
// Capture buffer and valid/ready serializer for the tile row.
// All col sums load in parallel on 'load'; while 'drain_en' is high the
// words are presented in index order and advance on each accepted transfer.
module os_drain_buf #(
    parameter int col     = 4,
    parameter int psum_bw = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [col*psum_bw-1:0]   tile_psum,
    input  logic                     drain_en,
    input  logic                     out_ready,
    output logic [psum_bw-1:0]       out_data,
    output logic [$clog2(col)-1:0]   out_idx,
    output logic                     out_valid,
    output logic                     last_xfer
);

    localparam int IW = $clog2(col);

    logic [psum_bw-1:0] cap_q [col];
    logic [IW-1:0]      idx_q;
    logic               fire;

    assign out_valid = drain_en;
    assign fire      = out_valid & out_ready;
    assign last_xfer = fire && (idx_q == IW'(col - 1));
    assign out_data  = cap_q[idx_q];
    assign out_idx   = idx_q;

    // Parallel capture of every tile's sum; cleared on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < col; i++) cap_q[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < col; i++) cap_q[i] <= tile_psum[i*psum_bw +: psum_bw];
        end
    end

    // Read index: restarts at capture, advances on each transfer, wraps after the last word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
        end else if (load) begin
            idx_q <= '0;
        end else if (fire) begin
            idx_q <= last_xfer ? '0 : idx_q + IW'(1);
        end
    end

endmodule

// File: rtl/os_psum_drain.sv
// Sequencer and read-out for a row of output-stationary MAC tiles.
// Runs the tiles for k_len fed cycles, lets their output registers settle,
// captures all sums, clears the tiles, then streams the sums out.
// Optional macro OS_DRAIN_ERR_EN: enables the sticky capture-error flag that
// reports any tile_valid bit low at capture time.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_IDLE    | waiting for start; k_len latched on start
//   ST_EXEC    | tiles execute on feed_valid cycles until k_len reached
//   ST_SETTLE  | one hold cycle for the tiles' output register
//   ST_CAPTURE | hold; all sums loaded into the buffer at exit edge
//   ST_CLEAR   | one clear instruction to the tiles
//   ST_DRAIN   | serialize col words over valid/ready
module os_psum_drain
    import os_pkg::*;
#(
    parameter int col     = 4,
    parameter int psum_bw = 16,
    parameter int kw      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [kw-1:0]            k_len,
    input  logic                     feed_valid,
    output logic [1:0]               inst_w,
    input  logic [col-1:0]           tile_valid,
    input  logic [col*psum_bw-1:0]   tile_psum,
    output logic [psum_bw-1:0]       out_data,
    output logic [$clog2(col)-1:0]   out_idx,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    state_t          state_q;
    logic [kw-1:0]   k_lat_q;
    logic [kw-1:0]   exec_cnt_q;
    logic            done_q;
    logic            last_xfer;
    logic            start_ok;

    assign start_ok = (state_q == ST_IDLE) && start;

    // Main sequencer, execute counter and done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            k_lat_q    <= '0;
            exec_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        k_lat_q    <= k_len;
                        exec_cnt_q <= '0;
                        state_q    <= (k_len == '0) ? ST_SETTLE : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // compare against k-1 so k_len = 2^kw-1 never needs a wider counter
                    if (feed_valid) begin
                        if (exec_cnt_q == k_lat_q - kw'(1)) begin
                            exec_cnt_q <= '0;
                            state_q    <= ST_SETTLE;
                        end else begin
                            exec_cnt_q <= exec_cnt_q + kw'(1);
                        end
                    end
                end
                ST_SETTLE:  state_q <= ST_CAPTURE;
                ST_CAPTURE: state_q <= ST_CLEAR;
                ST_CLEAR:   state_q <= ST_DRAIN;
                ST_DRAIN: begin
                    if (last_xfer) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Tile instruction decode; execute only issued on fed cycles
    always_comb begin
        inst_w = INST_HOLD;
        if (state_q == ST_EXEC && feed_valid) inst_w = INST_EXEC;
        else if (state_q == ST_CLEAR)         inst_w = INST_CLEAR;
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

    os_drain_buf #(
        .col     (col),
        .psum_bw (psum_bw)
    ) u_drain_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (state_q == ST_CAPTURE),
        .tile_psum (tile_psum),
        .drain_en  (state_q == ST_DRAIN),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .last_xfer (last_xfer)
    );

`ifdef OS_DRAIN_ERR_EN
    logic err_q;

    // Sticky error: set when a tile reports invalid at capture, cleared by a new pass
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (start_ok) begin
            err_q <= 1'b0;
        end else if (state_q == ST_CAPTURE && !(&tile_valid)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_tile_valid;
    logic unused_start_ok;

    assign unused_tile_valid = ^tile_valid;
    assign unused_start_ok   = start_ok;
    assign err               = 1'b0;
`endif

endmodule

// File: tb/tb_os_psum_drain.sv
// Directed bench for os_psum_drain with a scoreboard on the output stream.
module tb_os_psum_drain;
    import os_pkg::*;

    localparam int COL = 4;
    localparam int PBW = 16;
    localparam int KW  = 8;
    localparam int IW  = 2;
`ifdef OS_DRAIN_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [KW-1:0]        k_len = '0;
    logic                 feed_valid = 1'b0;
    logic [1:0]           inst_w;
    logic [COL-1:0]       tile_valid = '1;
    logic [COL*PBW-1:0]   tile_psum = '0;
    logic [PBW-1:0]       out_data;
    logic [IW-1:0]        out_idx;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic                 busy;
    logic                 done;
    logic                 err;

    int n_checks = 0;
    int n_errors = 0;
    int n_xfer   = 0;
    logic [IW+PBW-1:0] exp_q[$];

    os_psum_drain #(.col(COL), .psum_bw(PBW), .kw(KW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .k_len      (k_len),
        .feed_valid (feed_valid),
        .inst_w     (inst_w),
        .tile_valid (tile_valid),
        .tile_psum  (tile_psum),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tiles(input logic [PBW-1:0] v0, input logic [PBW-1:0] v1,
                             input logic [PBW-1:0] v2, input logic [PBW-1:0] v3);
        tile_psum = {v3, v2, v1, v0};
    endtask

    task automatic push_words(input logic [PBW-1:0] v0, input logic [PBW-1:0] v1,
                              input logic [PBW-1:0] v2, input logic [PBW-1:0] v3);
        exp_q.push_back({2'd0, v0});
        exp_q.push_back({2'd1, v1});
        exp_q.push_back({2'd2, v2});
        exp_q.push_back({2'd3, v3});
    endtask

    task automatic wait_done(input string name, input int budget, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            step();
            cycles++;
        end
        if (done !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: done not seen within %0d cycles", name, budget);
        end
    endtask

    // Stream monitor: pops expected words on transfers, checks hold while stalled
    logic              stall_pend = 1'b0;
    logic [IW+PBW-1:0] held = '0;
    always @(negedge clk) begin
        if (reset) begin
            stall_pend = 1'b0;
        end else if (out_valid) begin
            if (stall_pend) check("hold_stable", {out_idx, out_data}, held);
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL word_unexpected: got idx %0d data %0h, none expected", out_idx, out_data);
                end else begin
                    check("word", {out_idx, out_data}, exp_q.pop_front());
                end
                n_xfer++;
                stall_pend = 1'b0;
            end else begin
                stall_pend = 1'b1;
                held = {out_idx, out_data};
            end
        end else if (stall_pend) begin
            check("valid_held", out_valid, 1);
            stall_pend = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n;
        int c;
        int g;
        int base;
        logic [1:0] exp_inst1 [6];
        logic [1:0] exp_inst4 [3];
        bit pat2 [6];
        bit pat3 [5];
        exp_inst1 = '{INST_EXEC, INST_EXEC, INST_EXEC, INST_HOLD, INST_HOLD, INST_CLEAR};
        exp_inst4 = '{INST_HOLD, INST_HOLD, INST_CLEAR};
        pat2 = '{1, 0, 1, 1, 0, 1};
        pat3 = '{0, 1, 0, 0, 1};

        // reset values
        #12;
        check("rst_inst", inst_w, 0);
        check("rst_data", out_data, 0);
        check("rst_idx", out_idx, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // basic pass, k_len=3, continuous feed and ready
        set_tiles(16'd5, 16'd6, 16'd7, 16'd8);
        push_words(16'd5, 16'd6, 16'd7, 16'd8);
        k_len = 8'd3; feed_valid = 1'b1; out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) check("t1_inst", inst_w, exp_inst1[i]);
            check("t1_out_valid", out_valid, (i == 6));
            if (i < 6) step();
        end
        wait_done("t1_done", 20, cyc);
        check("t1_done_latency", cyc, 4);
        check("t1_busy_in_done", busy, 0);
        step();
        check("t1_done_once", done, 0);

        // gapped feed, k_len=4
        set_tiles(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        push_words(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        k_len = 8'd4; feed_valid = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            feed_valid = pat2[i];
            #1;
            if (inst_w == INST_EXEC) n++;
            step();
        end
        feed_valid = 1'b1;
        #1;
        check("t2_exec_count", n, 4);
        check("t2_settle_inst", inst_w, INST_HOLD);
        wait_done("t2_done", 30, cyc);
        check("t2_done_latency", cyc, 7);

        // back-pressure pattern 0,1,0,0,1 repeating
        set_tiles(16'hA0, 16'hA1, 16'hA2, 16'hA3);
        push_words(16'hA0, 16'hA1, 16'hA2, 16'hA3);
        base = n_xfer;
        k_len = 8'd1; out_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        c = 0;
        g = 0;
        while (done !== 1'b1 && g < 60) begin
            if (out_valid) begin
                out_ready = pat3[c % 5];
                c++;
            end
            step();
            g++;
        end
        if (done !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL t3_done: done not seen within 60 cycles");
        end
        check("t3_drain_cycles", c, 10);
        check("t3_xfers", n_xfer - base, 4);
        out_ready = 1'b1;
        step();

        // k_len=0 with all tiles invalid
        set_tiles(16'd0, 16'd0, 16'd0, 16'd0);
        push_words(16'd0, 16'd0, 16'd0, 16'd0);
        tile_valid = '0;
        k_len = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        check("t4_busy", busy, 1);
        for (int i = 0; i <= 3; i++) begin
            if (i < 3) check("t4_inst", inst_w, exp_inst4[i]);
            check("t4_out_valid", out_valid, (i == 3));
            if (i < 3) step();
        end
        wait_done("t4_done", 20, cyc);
        check("t4_err", err, ERR_EN);

        // next start clears err; reset mid-drain after index 1
        tile_valid = '1;
        set_tiles(16'h0101, 16'h0202, 16'h0303, 16'h0404);
        exp_q.push_back({2'd0, 16'h0101});
        exp_q.push_back({2'd1, 16'h0202});
        k_len = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        check("t4_err_cleared", err, 0);
        g = 0;
        while (!(out_valid === 1'b1 && out_idx == 2'd2) && g < 40) begin
            step();
            g++;
        end
        if (!(out_valid === 1'b1 && out_idx == 2'd2)) begin
            n_checks++;
            n_errors++;
            $display("FAIL t5_reach_idx2: index 2 not presented within 40 cycles");
        end
        reset = 1'b1;
        #1;
        check("t5_rst_inst", inst_w, 0);
        check("t5_rst_data", out_data, 0);
        check("t5_rst_idx", out_idx, 0);
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_err", err, 0);
        check("t5_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        reset = 1'b0;
        step();
        set_tiles(16'h00B0, 16'h00B1, 16'h00B2, 16'h00B3);
        push_words(16'h00B0, 16'h00B1, 16'h00B2, 16'h00B3);
        k_len = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        wait_done("t5_done", 30, cyc);
        check("t5_done_latency", cyc, 9);
        step();

        // start held high: second pass begins in the done cycle
        set_tiles(16'hC1, 16'hC2, 16'hC3, 16'hC4);
        push_words(16'hC1, 16'hC2, 16'hC3, 16'hC4);
        push_words(16'hC1, 16'hC2, 16'hC3, 16'hC4);
        k_len = 8'd1; start = 1'b1;
        step();
        wait_done("t6_done_a", 20, cyc);
        check("t6_busy_in_done", busy, 0);
        k_len = 8'd3;
        step();
        check("t6_restart", busy, 1);
        k_len = 8'd7;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (inst_w == INST_EXEC) n++;
            step();
        end
        check("t6_exec_count", n, 3);
        check("t6_settle_inst", inst_w, INST_HOLD);
        start = 1'b0;
        wait_done("t6_done_b", 20, cyc);
        step();
        check("t6_done_once", done, 0);
        repeat (3) step();
        check("t6_idle", busy, 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
